// File: rtl/pulse_gen_multi.sv
// rtl/pulse_gen_multi.sv - multi-channel debounced push-button pulse generator with auto-repeat
module pulse_gen_multi #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LEN       = 1,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  input  logic [N_CH-1:0] rep_en,
  output logic [N_CH-1:0] pulso,
  output logic [N_CH-1:0] held,
  output logic            any_pulse
);

  // One counter per channel serves every state, so it is sized for the largest limit.
  localparam int MAX_A   = (DEBOUNCE_CYCLES > PULSE_LEN) ? DEBOUNCE_CYCLES : PULSE_LEN;
  localparam int MAX_B   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] PL_LAST  = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_SAT  = '1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    PULSE    = 3'd2,
    HOLD     = 3'd3,
    DB_REL   = 3'd4
  } state_t;

  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;
  logic [N_CH-1:0] pulso_nxt;
  logic            any_pulse_q;

  // Two-flop synchronizer on the raw button levels; FSMs only see sync2_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            first_q, first_d;
    logic            pulso_q, held_q;
    logic            btn_s;
    logic [CW-1:0]   lim_last;

    assign btn_s    = sync2_q[i];
    // The first repeat waits the long delay; later ones use the short period.
    assign lim_last = first_q ? RD_LAST : RP_LAST;

    // Next-state logic; every state change reloads the counter with zero.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_d = DB_PRESS;
            cnt_d   = '0;
            first_d = 1'b1;
          end
        end
        DB_PRESS: begin
          if (!btn_s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = PULSE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PULSE: begin
          // A release during the pulse is ignored; the pulse always runs full length.
          if (cnt_q == PL_LAST) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HOLD: begin
          // >= lets a late rep_en fire at once from a saturated count.
          if (!btn_s) begin
            state_d = DB_REL;
            cnt_d   = '0;
          end else if (rep_en[i] && (cnt_q >= lim_last)) begin
            state_d = PULSE;
            cnt_d   = '0;
            first_d = 1'b0;
          end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DB_REL: begin
          if (btn_s) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // State, counter, repeat flag and Moore outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        first_q <= 1'b0;
        pulso_q <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        first_q <= first_d;
        pulso_q <= (state_d == PULSE);
        held_q  <= (state_d == PULSE) || (state_d == HOLD) || (state_d == DB_REL);
      end
    end

    assign pulso_nxt[i] = (state_d == PULSE);
    assign pulso[i]     = pulso_q;
    assign held[i]      = held_q;
  end

  // any_pulse is registered from the same next-state terms so it aligns with pulso.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      any_pulse_q <= 1'b0;
    end else begin
      any_pulse_q <= |pulso_nxt;
    end
  end

  assign any_pulse = any_pulse_q;

endmodule
